rx_unit: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/baud_tick_gen.sv | 31 +++
 rtl/rx_unit.sv | 153 +++++++++++++++
 tb/tb_rx_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default timing constants
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned TICK_DIV_DEF   = 54;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick divider: o_tick is high for one clock every
// TICK_DIV clocks. It is never resynchronised to line activity.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Divider counter, wraps after TICK_DIV-1.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign o_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/rx_unit.sv
// UART receiver: 16x-oversampled 8N1 deserialiser with a valid/read handshake,
// frame-error and overrun pulses, and break (held-low line) handling.
module rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned RX_DATA_SIZE = 8,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_rx,
  input  logic                    i_read,
  output logic [RX_DATA_SIZE-1:0] o_rxdata,
  output logic                    o_rxvalid,
  output logic                    o_frame_error,
  output logic                    o_overrun,
  output logic                    o_busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (RX_DATA_SIZE > 1) ? $clog2(RX_DATA_SIZE) : 1;
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(RX_DATA_SIZE - 1);

  logic                    sync1_q;
  logic                    sync2_q;
  logic                    rx_s;
  logic                    tick_s;
  uart_state_e             state_q;
  logic [CW-1:0]           cnt_q;
  logic [BW-1:0]           bitn_q;
  logic [RX_DATA_SIZE-1:0] shift_q;
  logic [RX_DATA_SIZE-1:0] rxdata_q;
  logic                    rxvalid_q;
  logic                    frame_err_q;
  logic                    overrun_q;

  baud_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .o_tick (tick_s)
  );

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Receive FSM with registered handshake and status outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shift_q     <= '0;
      rxdata_q    <= '0;
      rxvalid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A read clears valid unless a good frame lands in the same clock.
      if (i_read) begin
        rxvalid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (cnt_q == CNT_MID) begin
              if (!rx_s) begin
                state_q <= ST_DATA;
                cnt_q   <= '0;
                bitn_q  <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (cnt_q == CNT_LAST) begin
              shift_q <= {rx_s, shift_q[RX_DATA_SIZE-1:1]};
              cnt_q   <= '0;
              if (bitn_q == BIT_LAST) begin
                state_q <= ST_STOP;
              end else begin
                bitn_q <= bitn_q + BW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              // Decide at mid stop bit so back-to-back frames are not missed.
              if (rx_s) begin
                rxdata_q  <= shift_q;
                rxvalid_q <= 1'b1;
                overrun_q <= rxvalid_q & ~i_read;
                state_q   <= ST_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_BREAK;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rxdata      = rxdata_q;
  assign o_rxvalid     = rxvalid_q;
  assign o_frame_error = frame_err_q;
  assign o_overrun     = overrun_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_unit.sv
// Bench for rx_unit (TICK_DIV=1, OVERSAMPLE=16): a frame-timeline model checks
// the handshake outputs every cycle, plus hand-computed checks at key cycles.
module tb_rx_unit;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_read = 1'b0;
  logic [7:0] o_rxdata;
  logic       o_rxvalid;
  logic       o_frame_error;
  logic       o_overrun;
  logic       o_busy;

  always #5 clk = ~clk;

  rx_unit #(
    .RX_DATA_SIZE(8),
    .TICK_DIV    (1),
    .OVERSAMPLE  (16)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_rx         (i_rx),
    .i_read       (i_read),
    .o_rxdata     (o_rxdata),
    .o_rxvalid    (o_rxvalid),
    .o_frame_error(o_frame_error),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  // Frame completion is 155 edges after the edge that first samples the start bit
  // (2 sync + 8 clocks to mid start + 9 bit periods to mid stop + 1 register).
  localparam int LOAD_LAT = 155;

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         good;
  } evt_t;

  evt_t evq[$];
  evt_t ev;
  int   cyc = 0;
  logic rd_e = 1'b0;
  logic rst_e = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] m_data = 8'h00;
  bit   m_valid = 1'b0;
  bit   m_ferr;
  bit   m_ovr;
  bit   nv;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_e  <= i_read;
    rst_e <= i_reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    evt_t e;
    e.at   = cyc + LOAD_LAT;
    e.data = d;
    e.good = (stopb == 1'b1);
    evq.push_back(e);
    i_rx = 1'b0;
    wait_cyc(cyc + 16);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      wait_cyc(cyc + 16);
    end
    i_rx = stopb;
    wait_cyc(cyc + 16);
  endtask

  // Timeline model: applies the frame event or read seen at the last edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (rst_e) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        evq.delete();
      end else begin
        nv = rd_e ? 1'b0 : m_valid;
        if (evq.size() > 0 && evq[0].at == cyc) begin
          ev = evq.pop_front();
          if (ev.good) begin
            m_ovr  = m_valid && !rd_e;
            nv     = 1'b1;
            m_data = ev.data;
          end else begin
            m_ferr = 1'b1;
          end
        end
        m_valid = nv;
      end
      chk("model_rxvalid", 32'(o_rxvalid), 32'(m_valid));
      chk("model_rxdata", 32'(o_rxdata), 32'(m_data));
      chk("model_frame_error", 32'(o_frame_error), 32'(m_ferr));
      chk("model_overrun", 32'(o_overrun), 32'(m_ovr));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int h;
    wait_cyc(3);
    i_reset = 1'b0;
    wait_cyc(6);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_rxdata", 32'(o_rxdata), 32'h00);

    // Single frame 0xA5 and its read.
    wait_cyc(10);
    s = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_cyc(s + 2);  @(negedge clk); chk("a5_busy_pre", 32'(o_busy), 32'd0);
        wait_cyc(s + 3);  @(negedge clk); chk("a5_busy_start", 32'(o_busy), 32'd1);
        wait_cyc(s + 80); @(negedge clk); chk("a5_busy_mid", 32'(o_busy), 32'd1);
        wait_cyc(s + 154); @(negedge clk); chk("a5_valid_early", 32'(o_rxvalid), 32'd0);
        wait_cyc(s + 155); @(negedge clk);
        chk("a5_valid", 32'(o_rxvalid), 32'd1);
        chk("a5_data", 32'(o_rxdata), 32'hA5);
        chk("a5_busy_done", 32'(o_busy), 32'd0);
      end
    join
    i_read = 1'b1;
    s = cyc;
    wait_cyc(s + 1);
    i_read = 1'b0;
    @(negedge clk);
    chk("a5_read_clears", 32'(o_rxvalid), 32'd0);

    // Short low glitch is rejected at mid start bit.
    wait_cyc(cyc + 10);
    s = cyc;
    i_rx = 1'b0;
    wait_cyc(s + 4);
    i_rx = 1'b1;
    wait_cyc(s + 6);  @(negedge clk); chk("glitch_busy", 32'(o_busy), 32'd1);
    wait_cyc(s + 30); @(negedge clk); chk("glitch_idle", 32'(o_busy), 32'd0);
    chk("glitch_novalid", 32'(o_rxvalid), 32'd0);

    // Bad stop bit followed by a held-low break.
    wait_cyc(cyc + 10);
    s = cyc;
    fork
      begin
        send_frame(8'h3C, 1'b0);
        wait_cyc(s + 260);
      end
      begin
        wait_cyc(s + 155); @(negedge clk);
        chk("brk_ferr", 32'(o_frame_error), 32'd1);
        chk("brk_novalid", 32'(o_rxvalid), 32'd0);
        wait_cyc(s + 156); @(negedge clk); chk("brk_ferr_pulse", 32'(o_frame_error), 32'd0);
        wait_cyc(s + 220); @(negedge clk); chk("brk_busy", 32'(o_busy), 32'd1);
      end
    join
    h = cyc;
    i_rx = 1'b1;
    wait_cyc(h + 2); @(negedge clk); chk("brk_hold", 32'(o_busy), 32'd1);
    wait_cyc(h + 3); @(negedge clk); chk("brk_exit", 32'(o_busy), 32'd0);

    // Back-to-back frames without a read: overrun on the second.
    wait_cyc(cyc + 10);
    s = cyc;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        wait_cyc(s + 155); @(negedge clk); chk("b2b_first", 32'(o_rxdata), 32'h11);
        wait_cyc(s + 315); @(negedge clk);
        chk("b2b_second", 32'(o_rxdata), 32'h22);
        chk("b2b_overrun", 32'(o_overrun), 32'd1);
        chk("b2b_valid", 32'(o_rxvalid), 32'd1);
        wait_cyc(s + 316); @(negedge clk); chk("b2b_ovr_pulse", 32'(o_overrun), 32'd0);
      end
    join
    i_read = 1'b1;
    wait_cyc(cyc + 1);
    i_read = 1'b0;

    // Read lands on the same edge that loads the second word.
    wait_cyc(cyc + 10);
    s = cyc;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        wait_cyc(s + 314);
        i_read = 1'b1;
        wait_cyc(s + 315);
        i_read = 1'b0;
        @(negedge clk);
        chk("rdload_data", 32'(o_rxdata), 32'h22);
        chk("rdload_valid", 32'(o_rxvalid), 32'd1);
        chk("rdload_no_ovr", 32'(o_overrun), 32'd0);
      end
    join

    // Reset in the middle of the data bits, then a clean frame.
    wait_cyc(cyc + 10);
    s = cyc;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_cyc(s + 60);
        i_reset = 1'b1;
        wait_cyc(s + 61);
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_rxvalid), 32'd0);
        chk("rst_data", 32'(o_rxdata), 32'h00);
      end
    join
    wait_cyc(cyc + 10);
    s = cyc;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        wait_cyc(s + 155); @(negedge clk);
        chk("post_rst_valid", 32'(o_rxvalid), 32'd1);
        chk("post_rst_data", 32'(o_rxdata), 32'h5A);
      end
    join

    wait_cyc(cyc + 20);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
